// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared field indices, field ranges and scheduler states
//
// Purpose: constants and types shared by clock_field_sched and field_wrap_inc.
// Ports:   none (package).
package clock_pkg;

  localparam int NUM_FIELDS = 5;

  localparam logic [2:0] F_SEC   = 3'd0;
  localparam logic [2:0] F_MIN   = 3'd1;
  localparam logic [2:0] F_HOUR  = 3'd2;
  localparam logic [2:0] F_DAY   = 3'd3;
  localparam logic [2:0] F_MONTH = 3'd4;

  localparam int FIELD_MIN [NUM_FIELDS] = '{0, 0, 0, 1, 1};
  localparam int FIELD_MAX [NUM_FIELDS] = '{59, 59, 23, 31, 12};

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    FETCH = 2'd1,
    EDIT  = 2'd2,
    LOAD  = 2'd3
  } state_e;

endpackage

// File: rtl/field_wrap_inc.sv
// rtl/field_wrap_inc.sv - per-field wrapped increment and range clamp
//
// Purpose: combinational helper returning value+1 wrapped MAX->MIN for the
//          selected field, and value forced to MIN when outside [MIN, MAX].
// Ports:
//   value_i  in  DW  value to increment / clamp
//   field_i  in  3   field index (F_SEC..F_MONTH); other codes use sec range
//   inc_o    out DW  wrapped increment of value_i
//   clamp_o  out DW  value_i if in range, else field MIN
module field_wrap_inc
  import clock_pkg::*;
#(
  parameter int DW = 6
) (
  input  logic [DW-1:0] value_i,
  input  logic [2:0]    field_i,
  output logic [DW-1:0] inc_o,
  output logic [DW-1:0] clamp_o
);

  logic [DW-1:0] lo;
  logic [DW-1:0] hi;

  always_comb begin
    lo = DW'(FIELD_MIN[F_SEC]);
    hi = DW'(FIELD_MAX[F_SEC]);
    case (field_i)
      F_MIN: begin
        lo = DW'(FIELD_MIN[F_MIN]);
        hi = DW'(FIELD_MAX[F_MIN]);
      end
      F_HOUR: begin
        lo = DW'(FIELD_MIN[F_HOUR]);
        hi = DW'(FIELD_MAX[F_HOUR]);
      end
      F_DAY: begin
        lo = DW'(FIELD_MIN[F_DAY]);
        hi = DW'(FIELD_MAX[F_DAY]);
      end
      F_MONTH: begin
        lo = DW'(FIELD_MIN[F_MONTH]);
        hi = DW'(FIELD_MAX[F_MONTH]);
      end
      default: ;
    endcase
  end

  assign inc_o   = (value_i == hi) ? lo : value_i + 1'b1;
  assign clamp_o = ((value_i < lo) || (value_i > hi)) ? lo : value_i;

endmodule

// File: rtl/clock_field_sched.sv
// rtl/clock_field_sched.sv - shared counter bus scheduler with field edit sequencer
//
// Purpose: SCAN grants the bus round-robin (SCAN_DIV cycles per unit) and
//          republishes captured values; SET mode fetches, edits and loads
//          each field in turn. Optional macro FIELD_SET_TIMEOUT_EN returns
//          from EDIT to SCAN after TIMEOUT_CYC idle cycles.
// Ports:
//   clk, clear (sync active-high)      clock / reset
//   databus     in  DW       bus from counter units (valid while en bit high)
//   set_req, next_field, inc, commit   single-cycle user pulses
//   en, ld      out NFIELDS  one-hot-or-zero bus grant / load strobe
//   data        out DW       load data (held between loads)
//   scan_field, scan_value, scan_valid  last captured field/value + pulse
//   set_active  out 1        high in FETCH/EDIT/LOAD
//   sel_field   out 3        field being edited
module clock_field_sched
  import clock_pkg::*;
#(
  parameter int NFIELDS     = 5,
  parameter int DW          = 6,
  parameter int SCAN_DIV    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [DW-1:0]      databus,
  input  logic               set_req,
  input  logic               next_field,
  input  logic               inc,
  input  logic               commit,
  output logic [NFIELDS-1:0] en,
  output logic [NFIELDS-1:0] ld,
  output logic [DW-1:0]      data,
  output logic [2:0]         scan_field,
  output logic [DW-1:0]      scan_value,
  output logic               scan_valid,
  output logic               set_active,
  output logic [2:0]         sel_field
);

  localparam int               SLOT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [2:0]       LAST_FIELD = 3'(NFIELDS - 1);

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          sel_q, sel_d;
  logic [DW-1:0]       edit_q, edit_d;
  logic [NFIELDS-1:0]  en_q, en_d;
  logic [NFIELDS-1:0]  ld_q, ld_d;
  logic [DW-1:0]       data_q, data_d;
  logic [2:0]          scan_field_q, scan_field_d;
  logic [DW-1:0]       scan_value_q, scan_value_d;
  logic                scan_valid_q, scan_valid_d;
  logic                set_active_q;
  logic                advance;
  logic                timeout_hit;
  logic [DW-1:0]       wrap_value, wrap_inc, wrap_clamp;

  // Only FETCH needs the clamp of the bus; every other state uses the increment of edit_q.
  assign wrap_value = (state_q == FETCH) ? databus : edit_q;

  field_wrap_inc #(.DW(DW)) u_wrap (
    .value_i (wrap_value),
    .field_i (sel_q),
    .inc_o   (wrap_inc),
    .clamp_o (wrap_clamp)
  );

`ifdef FIELD_SET_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic              edit_idle;
  logic [IDLE_W-1:0] idle_q, idle_d;

  assign edit_idle   = (state_q == EDIT) && !(inc || next_field || commit);
  assign timeout_hit = edit_idle && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_d = '0;
    if (edit_idle) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    idx_d        = idx_q;
    sel_d        = sel_q;
    edit_d       = edit_q;
    ld_d         = '0;
    data_d       = data_q;
    scan_field_d = scan_field_q;
    scan_value_d = scan_value_q;
    scan_valid_d = 1'b0;
    advance      = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (set_req) begin
          state_d = FETCH;
          sel_d   = '0;
          slot_d  = '0;
        end else if (en_q == '0) begin
          // Cycle right after clear: grant not yet on the bus, slot does not count.
          slot_d = '0;
        end else if (slot_q == SLOT_LAST) begin
          scan_field_d = idx_q;
          scan_value_d = databus;
          scan_valid_d = 1'b1;
          slot_d       = '0;
          idx_d        = (idx_q == LAST_FIELD) ? 3'd0 : idx_q + 3'd1;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      FETCH: begin
        edit_d  = wrap_clamp;
        state_d = EDIT;
      end
      EDIT: begin
        if (commit) begin
          state_d = LOAD;
          ld_d    = NFIELDS'(1) << sel_q;
          data_d  = edit_q;
        end else if (next_field) begin
          advance = 1'b1;
        end else if (inc) begin
          edit_d = wrap_inc;
        end else if (timeout_hit) begin
          state_d = SCAN;
          idx_d   = '0;
          slot_d  = '0;
          sel_d   = '0;
        end
      end
      LOAD: advance = 1'b1;
      default: ;
    endcase

    if (advance) begin
      if (sel_q == LAST_FIELD) begin
        state_d = SCAN;
        idx_d   = '0;
        slot_d  = '0;
        sel_d   = '0;
      end else begin
        state_d = FETCH;
        sel_d   = sel_q + 3'd1;
      end
    end

    // The grant register follows the next state so en lines up with it.
    en_d = '0;
    if (state_d == SCAN)       en_d = NFIELDS'(1) << idx_d;
    else if (state_d == FETCH) en_d = NFIELDS'(1) << sel_d;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= SCAN;
      slot_q       <= '0;
      idx_q        <= '0;
      sel_q        <= '0;
      edit_q       <= '0;
      en_q         <= '0;
      ld_q         <= '0;
      data_q       <= '0;
      scan_field_q <= '0;
      scan_value_q <= '0;
      scan_valid_q <= 1'b0;
      set_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      edit_q       <= edit_d;
      en_q         <= en_d;
      ld_q         <= ld_d;
      data_q       <= data_d;
      scan_field_q <= scan_field_d;
      scan_value_q <= scan_value_d;
      scan_valid_q <= scan_valid_d;
      set_active_q <= (state_d != SCAN);
    end
  end

  assign en         = en_q;
  assign ld         = ld_q;
  assign data       = data_q;
  assign scan_field = scan_field_q;
  assign scan_value = scan_value_q;
  assign scan_valid = scan_valid_q;
  assign set_active = set_active_q;
  assign sel_field  = sel_q;

endmodule

// File: doc/clock_field_sched.md
Name: clock_field_sched

Overview:
- Scheduler/controller for the shared counter databus of the digital clock (sec, min, hour, day, month units).
- Each counter unit drives the bus only when its enable is high (bus = en & value) and takes its data input on a load strobe.
- SCAN mode: the block grants the bus round-robin to each unit and republishes the captured values to the display.
- SET mode: it sequences a user edit of each field: fetch, edit, then a one-cycle load strobe.

Parameters:
- NFIELDS, 5: number of counter units; index 0=sec, 1=min, 2=hour, 3=day, 4=month.
- DW, 6: data/bus width.
- SCAN_DIV, 4: cycles per scan slot, must be >=1.
- TIMEOUT_CYC, 1024: idle cycles before auto-exit (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  reset; synchronous, active-high.
- databus  in  DW  shared bus from the counter units; combinational and valid in the cycle its en bit is high.
- set_req  in  1  single-cycle pulse: enter SET mode.
- next_field  in  1  pulse: skip the current field with no load.
- inc  in  1  pulse: increment the edit value.
- commit  in  1  pulse: load the edit value into the current field.
- en  out  NFIELDS  one-hot or zero bus grant.
- ld  out  NFIELDS  one-hot or zero load strobe.
- data  out  DW  load data.
- scan_field  out  3  index of the last captured field.
- scan_value  out  DW  last captured value.
- scan_valid  out  1  one-cycle pulse on each capture.
- set_active  out  1  high in any SET state.
- sel_field  out  3  field being edited.

Behaviour:
- Reset (clear=1 at an edge):
  - State=SCAN; slot counter=0; scan index=0.
  - en=0, ld=0, data=0, scan_field=0, scan_value=0, scan_valid=0, set_active=0, sel_field=0.
  - Reset mid-SET abandons the edit; no ld is ever issued.
- Bus rule:
  - en has at most one bit set.
  - ld has at most one bit set.
  - en and ld are never high in the same cycle.
  - All outputs are registered.
- SCAN state:
  - en[idx] is held for SCAN_DIV cycles.
  - In the last cycle of the slot, databus is captured into scan_value and idx into scan_field.
  - scan_valid pulses in the following cycle.
  - idx then wraps NFIELDS-1 -> 0.
  - set_req -> FETCH with sel_field=0. The current slot is abandoned and no capture occurs.
- FETCH state (1 cycle):
  - en[sel]=1 and databus is captured into edit_val.
  - Next state is EDIT.
- EDIT state (en=0). Priority: commit > next_field > inc.
  - inc: edit_val = (edit_val==MAX[sel]) ? MIN[sel] : edit_val+1.
  - commit -> LOAD.
  - next_field: advance to FETCH of sel+1; after sel=NFIELDS-1, go to SCAN at idx 0.
  - set_req is ignored.
- LOAD state (1 cycle):
  - ld[sel]=1 and data=edit_val.
  - Then advance exactly as next_field does.
- Field ranges (MIN/MAX):
  - sec 0/59, min 0/59, hour 0/23, day 1/31, month 1/12.
- Out-of-range fetch: a fetched value outside [MIN, MAX] is forced to MIN in edit_val.
- data holds its last loaded value when ld=0.
- Inputs arriving in FETCH or LOAD are ignored; they are not queued.
- Exiting to SCAN restarts the slot counter at 0.

Optional Feature:
- Macro: FIELD_SET_TIMEOUT_EN.
- Defined:
  - An idle counter runs in EDIT and resets on any inc, next_field or commit.
  - After TIMEOUT_CYC idle cycles the block returns to SCAN at idx 0 with no ld.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Undefined: EDIT waits indefinitely and TIMEOUT_CYC is unused.

Decomposition:
- Package clock_pkg holds:
  - Field index constants (F_SEC..F_MONTH).
  - FIELD_MIN and FIELD_MAX constant arrays.
  - State enum {SCAN, FETCH, EDIT, LOAD}.
- One natural sub-module: field_wrap_inc (combinational, with inputs value and field index). It yields the wrapped increment and the range clamp.

Test Plan:
1. Reset, then SCAN with counters sec=42, min=7, hour=13, day=5, month=9 and SCAN_DIV=4.
   - en rotates 00001 -> 10000, one slot every 4 cycles.
   - scan_valid pulses with (0,42), (1,7), (2,13), (3,5), (4,9), then the rotation wraps.
2. set_req; fetch sec=58; inc x2; commit.
   - FETCH shows en=00001 for 1 cycle.
   - Edit value goes 59 -> 0.
   - ld=00001 for exactly 1 cycle with data=0.
   - sel_field then becomes 1.
3. Month=12 fetched; inc -> 1; commit.
   - ld=10000 with data=1.
   - Return to SCAN with en=00001.
4. Day fetched as 0 (out of range).
   - edit_val=1.
   - inc and commit in the same cycle: commit wins and ld carries data=1.
5. clear asserted while in EDIT at sel=2.
   - Next cycle: all outputs 0, state SCAN, and ld never pulses.
6. With FIELD_SET_TIMEOUT_EN and TIMEOUT_CYC=16, enter EDIT with no input for 16 cycles.
   - Block returns to SCAN and no ld occurs.
   - With the macro undefined, the block is still in EDIT after 100 cycles.
